// File: rtl/column_flattener.sv
// rtl/column_flattener.sv - expands column records into per-row frame-buffer pixel writes (option: FLATTENER_SIDE_SHADE_EN)
module column_flattener #(
    parameter int                     PIXEL_WIDTH   = 16,
    parameter int                     SCREEN_WIDTH  = 320,
    parameter int                     SCREEN_HEIGHT = 180,
    parameter int                     HCOUNT_WIDTH  = 9,
    parameter int                     LH_WIDTH      = 8,
    parameter int                     ADDR_WIDTH    = 16,
    parameter logic [PIXEL_WIDTH-1:0] CEIL_COLOR    = 16'hFFFF,
    parameter logic [PIXEL_WIDTH-1:0] FLOOR_COLOR   = 16'h8410,
    parameter logic [PIXEL_WIDTH-1:0] WALL_STEP     = 16'h1082
) (
    input  logic                                 pixel_clk_in,
    input  logic                                 rst_n_in,
    input  logic                                 dda_fifo_tvalid_in,
    input  logic [HCOUNT_WIDTH+LH_WIDTH+21-1:0]  dda_fifo_tdata_in,
    input  logic                                 dda_fifo_tlast_in,
    output logic                                 transformer_tready_out,
    input  logic                                 pix_ready_in,
    output logic                                 ray_pixel_valid_out,
    output logic [ADDR_WIDTH-1:0]                ray_address_out,
    output logic [PIXEL_WIDTH-1:0]               ray_pixel_out,
    output logic                                 ray_last_pixel_out,
    output logic                                 col_err_out
);

    localparam int TW    = HCOUNT_WIDTH + LH_WIDTH + 21;
    localparam int ROW_W = $clog2(SCREEN_HEIGHT);
    localparam int BW    = (LH_WIDTH + 1 > ROW_W + 1) ? LH_WIDTH + 1 : ROW_W + 1;
    localparam logic [BW-1:0]           HH       = BW'(SCREEN_HEIGHT / 2);
    localparam logic [BW-1:0]           SH       = BW'(SCREEN_HEIGHT);
    localparam logic [HCOUNT_WIDTH:0]   SW_LIMIT = (HCOUNT_WIDTH + 1)'(SCREEN_WIDTH);
    localparam logic [ROW_W-1:0]        LAST_ROW = ROW_W'(SCREEN_HEIGHT - 1);

    typedef enum logic {IDLE, FLATTEN} state_e;

    // Record fields, MSB first: hcount, line_height, wall_type, map_data, wallX
    logic [HCOUNT_WIDTH-1:0] in_hcount;
    logic [LH_WIDTH-1:0]     in_lh;
    logic                    in_wall_type;
    logic [3:0]              in_map;
    logic [15:0]             in_wall_x;
    logic                    unused_fields;

    assign in_hcount    = dda_fifo_tdata_in[TW-1 -: HCOUNT_WIDTH];
    assign in_lh        = dda_fifo_tdata_in[20+LH_WIDTH -: LH_WIDTH];
    assign in_wall_type = dda_fifo_tdata_in[20];
    assign in_map       = dda_fifo_tdata_in[19:16];
    assign in_wall_x    = dda_fifo_tdata_in[15:0];

    // Wall colour is a scaled step; truncation to PIXEL_WIDTH is intentional
    logic [PIXEL_WIDTH-1:0] wall_raw;
    logic [PIXEL_WIDTH-1:0] wall_color;
    assign wall_raw = PIXEL_WIDTH'(in_map) * WALL_STEP;

`ifdef FLATTENER_SIDE_SHADE_EN
    assign wall_color    = in_wall_type ? ((wall_raw >> 1) & PIXEL_WIDTH'(16'h7BEF)) : wall_raw;
    assign unused_fields = ^in_wall_x;
`else
    assign wall_color    = wall_raw;
    assign unused_fields = ^{in_wall_x, in_wall_type};
`endif

    // Draw bounds from the incoming line height; map 0 collapses the wall band onto HH
    logic [BW-1:0] half, sum, bnd_start, bnd_end;
    always_comb begin
        half      = BW'(in_lh) >> 1;
        sum       = HH + half;
        bnd_start = (half >= HH) ? '0 : HH - half;
        bnd_end   = (sum > SH) ? SH : sum;
        if (in_map == 4'd0) begin
            bnd_start = HH;
            bnd_end   = HH;
        end
    end

    state_e                  state_q, state_d;
    logic                    tready_q, tready_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [ADDR_WIDTH-1:0]   acc_q, acc_d;
    logic [BW-1:0]           start_q, start_d, end_q, end_d;
    logic [PIXEL_WIDTH-1:0]  wall_q, wall_d;
    logic                    tlast_q, tlast_d;
    logic                    valid_q, valid_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [PIXEL_WIDTH-1:0]  pix_q, pix_d;
    logic                    last_q, last_d;
    logic                    err_q, err_d;
    logic                    slot_free;
    logic [PIXEL_WIDTH-1:0]  row_color;

    // Next-state, record latch and output-slot loading
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        acc_d     = acc_q;
        start_d   = start_q;
        end_d     = end_q;
        wall_d    = wall_q;
        tlast_d   = tlast_q;
        valid_d   = valid_q;
        addr_d    = addr_q;
        pix_d     = pix_q;
        last_d    = last_q;
        err_d     = err_q;
        slot_free = !valid_q || pix_ready_in;

        if (BW'(row_q) < start_q)    row_color = CEIL_COLOR;
        else if (BW'(row_q) < end_q) row_color = wall_q;
        else                         row_color = FLOOR_COLOR;

        if (slot_free) valid_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (dda_fifo_tvalid_in && tready_q) begin
                    if ({1'b0, in_hcount} >= SW_LIMIT) begin
                        err_d = 1'b1;
                    end else begin
                        row_d   = '0;
                        acc_d   = ADDR_WIDTH'(in_hcount);
                        start_d = bnd_start;
                        end_d   = bnd_end;
                        wall_d  = wall_color;
                        tlast_d = dda_fifo_tlast_in;
                        state_d = FLATTEN;
                    end
                end
            end
            FLATTEN: begin
                if (slot_free) begin
                    valid_d = 1'b1;
                    addr_d  = acc_q;
                    pix_d   = row_color;
                    last_d  = (row_q == LAST_ROW) && tlast_q;
                    acc_d   = acc_q + ADDR_WIDTH'(SCREEN_WIDTH);
                    row_d   = row_q + ROW_W'(1);
                    if (row_q == LAST_ROW) state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        tready_d = (state_d == IDLE);
    end

    // State and datapath registers, all cleared asynchronously
    always_ff @(posedge pixel_clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q  <= IDLE;
            tready_q <= 1'b0;
            row_q    <= '0;
            acc_q    <= '0;
            start_q  <= '0;
            end_q    <= '0;
            wall_q   <= '0;
            tlast_q  <= 1'b0;
            valid_q  <= 1'b0;
            addr_q   <= '0;
            pix_q    <= '0;
            last_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            tready_q <= tready_d;
            row_q    <= row_d;
            acc_q    <= acc_d;
            start_q  <= start_d;
            end_q    <= end_d;
            wall_q   <= wall_d;
            tlast_q  <= tlast_d;
            valid_q  <= valid_d;
            addr_q   <= addr_d;
            pix_q    <= pix_d;
            last_q   <= last_d;
            err_q    <= err_d;
        end
    end

    assign transformer_tready_out = tready_q;
    assign ray_pixel_valid_out    = valid_q;
    assign ray_address_out        = addr_q;
    assign ray_pixel_out          = pix_q;
    assign ray_last_pixel_out     = last_q;
    assign col_err_out            = err_q;

endmodule

// File: tb/tb_column_flattener.sv
// tb/tb_column_flattener.sv - self-checking bench for column_flattener
module tb_column_flattener;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tvalid;
    logic [37:0] tdata;
    logic        tlast;
    logic        tready;
    logic        pix_ready;
    logic        valid;
    logic [15:0] addr;
    logic [15:0] pix;
    logic        last;
    logic        err;

    always #5 clk = ~clk;

    column_flattener dut (
        .pixel_clk_in           (clk),
        .rst_n_in               (rst_n),
        .dda_fifo_tvalid_in     (tvalid),
        .dda_fifo_tdata_in      (tdata),
        .dda_fifo_tlast_in      (tlast),
        .transformer_tready_out (tready),
        .pix_ready_in           (pix_ready),
        .ray_pixel_valid_out    (valid),
        .ray_address_out        (addr),
        .ray_pixel_out          (pix),
        .ray_last_pixel_out     (last),
        .col_err_out            (err)
    );

    typedef struct {
        int addr;
        int pix;
        int last;
    } beat_t;

    typedef struct {
        int h;
        int lh;
        int wt;
        int mp;
        int tl;
        int exp_start;
        int exp_end;
        int exp_wall;
    } vec_t;

    beat_t exp_q[$];
    vec_t  vecs[9];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;
    int    ready_mode = 0;
    int    first_pop_cyc;
    int    last_pop_cyc;
    int    hs_cyc;

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    // Expected pixel stream of one column from its colour bands
    function automatic void push_column(input int h, input int st, input int en,
                                        input int wall, input int wt, input int tl);
        int shaded;
        shaded = wall;
`ifdef FLATTENER_SIDE_SHADE_EN
        if (wt == 1) shaded = (wall / 2) & 'h7BEF;
`endif
        for (int r = 0; r < 180; r++) begin
            beat_t b;
            b.addr = h + r * 320;
            if (r < st)      b.pix = 'hFFFF;
            else if (r < en) b.pix = shaded;
            else             b.pix = 'h8410;
            b.last = (r == 179 && tl == 1) ? 1 : 0;
            exp_q.push_back(b);
        end
    endfunction

    function automatic void model_column(input int h, input int lh, input int wt,
                                         input int mp, input int tl);
        int half, st, en;
        if (h >= 320) return;
        half = lh / 2;
        st   = (half >= 90) ? 0 : 90 - half;
        en   = (90 + half > 180) ? 180 : 90 + half;
        if (mp == 0) begin
            st = 90;
            en = 90;
        end
        push_column(h, st, en, (mp * 'h1082) & 'hFFFF, wt, tl);
    endfunction

    task automatic send(input int h, input int lh, input int wt, input int mp, input int tl);
        int k = 0;
        @(posedge clk);
        #1;
        tvalid = 1'b1;
        tdata  = {9'(h), 8'(lh), 1'(wt), 4'(mp), 16'($urandom)};
        tlast  = tl[0];
        while (!tready && k < 1000) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("tready_wait_timeout", int'(tready), 1);
        first_pop_cyc = -1;
        @(posedge clk);
        #1;
        hs_cyc = cyc;
        tvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        check("drain_timeout", exp_q.size(), 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output ready pattern: 0 always, 1 repeating 1,0,0, 2 random
    initial begin
        int phase = 0;
        pix_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       pix_ready = 1'b1;
                1:       begin pix_ready = (phase % 3 == 0); phase++; end
                default: pix_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Scoreboard and stall-stability monitor, sampled away from the clock edge
    initial begin
        logic        held = 1'b0;
        logic [15:0] h_addr, h_pix;
        logic        h_last;
        forever begin
            @(negedge clk);
            if (rst_n && valid) begin
                if (held)
                    check("stall_stable", int'({addr, pix, last}), int'({h_addr, h_pix, h_last}));
                if (pix_ready) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_beat", int'(addr), -1);
                    end else begin
                        beat_t e;
                        e = exp_q.pop_front();
                        check("addr", int'(addr), e.addr);
                        check("pixel", int'(pix), e.pix);
                        check("last", int'(last), e.last);
                        if (first_pop_cyc < 0) first_pop_cyc = cyc;
                        last_pop_cyc = cyc;
                    end
                end
                held   = !pix_ready;
                h_addr = addr;
                h_pix  = pix;
                h_last = last;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: actual timeout required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int h, lh, wt, mp, tl;
        rst_n  = 1'b0;
        tvalid = 1'b0;
        tdata  = '0;
        tlast  = 1'b0;

        vecs[0] = '{5,   60,  0, 1,  0, 60, 120, 'h1082};
        vecs[1] = '{319, 255, 0, 2,  1, 0,  180, 'h2104};
        vecs[2] = '{0,   61,  0, 3,  0, 60, 120, 'h3186};
        vecs[3] = '{100, 0,   0, 1,  1, 90, 90,  'h1082};
        vecs[4] = '{7,   200, 1, 0,  0, 90, 90,  'h0000};
        vecs[5] = '{200, 179, 0, 15, 0, 1,  179, 'hF79E};
        vecs[6] = '{10,  180, 0, 4,  1, 0,  180, 'h4208};
        vecs[7] = '{318, 1,   1, 8,  0, 90, 90,  'h8410};
        vecs[8] = '{20,  60,  1, 1,  0, 60, 120, 'h1082};

        repeat (3) @(posedge clk);
        #1;
        check("reset_tready", int'(tready), 0);
        check("reset_valid", int'(valid), 0);
        check("reset_addr", int'(addr), 0);
        check("reset_pixel", int'(pix), 0);
        check("reset_last", int'(last), 0);
        check("reset_err", int'(err), 0);
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("tready_after_reset", int'(tready), 1);

        for (int i = 0; i < 9; i++) begin
            push_column(vecs[i].h, vecs[i].exp_start, vecs[i].exp_end,
                        vecs[i].exp_wall, vecs[i].wt, vecs[i].tl);
            send(vecs[i].h, vecs[i].lh, vecs[i].wt, vecs[i].mp, vecs[i].tl);
            wait_drain();
            if (i == 0) begin
                check("throughput_span", last_pop_cyc - first_pop_cyc, 179);
                check("first_pixel_latency_ok",
                      int'(first_pop_cyc - hs_cyc >= 1 && first_pop_cyc - hs_cyc <= 2), 1);
            end
        end

        send(320, 60, 0, 1, 0);
        check("col_err_set", int'(err), 1);
        check("tready_after_err", int'(tready), 1);
        begin
            int seen = 0;
            repeat (5) begin
                @(negedge clk);
                if (valid) seen++;
            end
            check("no_beat_on_err", seen, 0);
        end
        model_column(12, 90, 0, 1, 0);
        send(12, 90, 0, 1, 0);
        wait_drain();
        check("col_err_sticky", int'(err), 1);

        ready_mode = 1;
        model_column(5, 60, 0, 1, 0);
        send(5, 60, 0, 1, 0);
        wait_drain();

        ready_mode = 2;
        for (int i = 0; i < 12; i++) begin
            h  = $urandom_range(0, 330);
            lh = $urandom_range(0, 255);
            wt = $urandom_range(0, 1);
            mp = $urandom_range(0, 15);
            tl = $urandom_range(0, 1);
            model_column(h, lh, wt, mp, tl);
            send(h, lh, wt, mp, tl);
            wait_drain();
        end

        ready_mode = 0;
        model_column(3, 100, 0, 5, 1);
        send(3, 100, 0, 5, 1);
        begin
            int k = 0;
            while (exp_q.size() > 90 && k < 1000) begin
                @(negedge clk);
                k++;
            end
            check("reach_row_90", int'(exp_q.size() <= 90), 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check("midreset_valid", int'(valid), 0);
        check("midreset_addr", int'(addr), 0);
        check("midreset_pixel", int'(pix), 0);
        check("midreset_last", int'(last), 0);
        check("midreset_tready", int'(tready), 0);
        check("midreset_err", int'(err), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        model_column(4, 20, 0, 6, 0);
        send(4, 20, 0, 6, 0);
        wait_drain();

        repeat (5) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
